// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard sources in, pipeline enables/bubbles out.
`default_nettype none
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rt;
  logic              ex_redirect;
  logic              ex_mdu_start;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              mdu_busy;
  logic              mdu_done;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_redirect, ex_mdu_start,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, mdu_busy, mdu_done
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_redirect, ex_mdu_start,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, mdu_busy, mdu_done
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage MIPS hazard controller: load-use stall, redirect squash, MDU freeze FSM.
// Optional HAZ_PERF_CNT_EN adds saturating stall_cycles/flush_cycles counters.
`default_nettype none
module pipeline_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 6
) (
  input  wire logic            clk,
  input  wire logic            reset,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_BUSY = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  localparam logic [REG_AW-1:0] ZERO_REG  = '0;
  localparam logic [CNT_W-1:0]  CNT_START = CNT_W'(MDU_LATENCY - 2);

  state_t           state_q;
  logic [CNT_W-1:0] count_q;

  logic load_use;
  logic freeze;
  logic pc_write_w;
  logic if_id_write_w;
  logic if_id_flush_w;
  logic id_ex_bubble_w;

  assign load_use = hz.ex_mem_read && (hz.ex_rt != ZERO_REG) &&
                    ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

  assign freeze = ((state_q == RUN) && hz.ex_mdu_start) || (state_q == MDU_BUSY);

  always_comb begin
    pc_write_w     = 1'b1;
    if_id_write_w  = 1'b1;
    if_id_flush_w  = 1'b0;
    id_ex_bubble_w = 1'b0;
    if (!reset) begin
      pc_write_w     = 1'b0;
      if_id_write_w  = 1'b0;
      if_id_flush_w  = 1'b1;
      id_ex_bubble_w = 1'b1;
    end else if (hz.ex_redirect) begin
      // Squash both younger slots while the PC loads the target.
      if_id_flush_w  = 1'b1;
      id_ex_bubble_w = 1'b1;
    end else if (freeze || load_use) begin
      pc_write_w     = 1'b0;
      if_id_write_w  = 1'b0;
      id_ex_bubble_w = 1'b1;
    end
  end

  assign hz.pc_write     = pc_write_w;
  assign hz.if_id_write  = if_id_write_w;
  assign hz.if_id_flush  = if_id_flush_w;
  assign hz.id_ex_bubble = id_ex_bubble_w;
  assign hz.mdu_busy     = reset && (state_q == MDU_BUSY);
  assign hz.mdu_done     = reset && (state_q == DRAIN);

  // The start cycle itself is the first freeze cycle, hence the LATENCY-2 preload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      count_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (hz.ex_mdu_start && !hz.ex_redirect) begin
            state_q <= MDU_BUSY;
            count_q <= CNT_START;
          end
        end
        MDU_BUSY: begin
          if (count_q == '0) begin
            state_q <= DRAIN;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        DRAIN: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= RUN;
          count_q <= '0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (!pc_write_w && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (hz.ex_redirect && (flush_cycles != 32'hFFFF_FFFF)) begin
        flush_cycles <= flush_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
